fetch_redirect_ctrl: RTL and testbench

- Controller that drives the control side of the fetch/control interface: update_pc, update_addr, flush, stall.
- Arbitrates PC-redirect requests from four sources: trap, return-from-trap, branch mispredict and jump.
- Holds a redirect pending while the instruction memory transaction is in flight.
- Sequences a multi-cycle flush of wrong-path fetch state.
- Sits between execute/CSR logic and the fetch stage of the two-stage pipeline.

---
 rtl/tspp_types_pkg.sv | 36 +++
 rtl/fetch_control_if.sv | 23 ++
 rtl/redirect_prio_sel.sv | 39 +++
 rtl/fetch_redirect_ctrl.sv | 159 +++++++++++++++
 tb/tb_fetch_redirect_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tspp_types_pkg.sv
// Shared types for the fetch-side control logic: redirect source ranking and
// the redirect controller state encoding.
package tspp_types_pkg;

    // Numeric order of the encoding equals redirect priority.
    typedef enum logic [2:0] {
        RS_NONE = 3'd0,
        RS_JMP  = 3'd1,
        RS_BR   = 3'd2,
        RS_RET  = 3'd3,
        RS_TRAP = 3'd4
    } redirect_src_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        FLUSH   = 2'd2
    } fetch_redirect_state_t;

    localparam int FLUSH_CNT_W = 4;

    // One-hot grant vector ordered {trap, ret, br, jmp}.
    function automatic logic [3:0] src_to_grant(input redirect_src_t src);
        logic [3:0] g;
        g = 4'b0000;
        case (src)
            RS_TRAP: g = 4'b1000;
            RS_RET:  g = 4'b0100;
            RS_BR:   g = 4'b0010;
            RS_JMP:  g = 4'b0001;
            default: g = 4'b0000;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/fetch_control_if.sv
// Control-side signals passed from the redirect controller to the fetch stage.
interface fetch_control_if #(
    parameter int ADDR_W = 32
);
    logic              update_pc;
    logic [ADDR_W-1:0] update_addr;
    logic              flush;
    logic              stall;

    modport control (
        output update_pc,
        output update_addr,
        output flush,
        output stall
    );

    modport fetch (
        input update_pc,
        input update_addr,
        input flush,
        input stall
    );
endinterface

// File: rtl/redirect_prio_sel.sv
// Fixed-priority redirect selector: trap > ret > br > jmp, purely combinational.
module redirect_prio_sel
    import tspp_types_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              trap_req,
    input  logic [ADDR_W-1:0] trap_addr,
    input  logic              ret_req,
    input  logic [ADDR_W-1:0] ret_addr,
    input  logic              br_req,
    input  logic [ADDR_W-1:0] br_addr,
    input  logic              jmp_req,
    input  logic [ADDR_W-1:0] jmp_addr,
    output redirect_src_t     win_src,
    output logic [ADDR_W-1:0] win_addr,
    output logic [3:0]        win_grant
);

    always_comb begin
        win_src  = RS_NONE;
        win_addr = '0;
        if (trap_req) begin
            win_src  = RS_TRAP;
            win_addr = trap_addr;
        end else if (ret_req) begin
            win_src  = RS_RET;
            win_addr = ret_addr;
        end else if (br_req) begin
            win_src  = RS_BR;
            win_addr = br_addr;
        end else if (jmp_req) begin
            win_src  = RS_JMP;
            win_addr = jmp_addr;
        end
        win_grant = src_to_grant(win_src);
    end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Redirect controller: arbitrates PC redirects, holds one while imem is busy,
// and sequences the wrong-path flush toward the fetch stage.
module fetch_redirect_ctrl
    import tspp_types_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int ADDR_W       = 32
) (
    input  logic              CLK,
    input  logic              RST,
    fetch_control_if.control  fcif,
    input  logic              trap_req,
    input  logic [ADDR_W-1:0] trap_addr,
    input  logic              ret_req,
    input  logic [ADDR_W-1:0] ret_addr,
    input  logic              br_req,
    input  logic [ADDR_W-1:0] br_addr,
    input  logic              jmp_req,
    input  logic [ADDR_W-1:0] jmp_addr,
    input  logic              hazard_stall,
    input  logic              fetch_busy,
    output logic [3:0]        grant
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
    localparam fetch_redirect_state_t  ISSUE_NEXT   = (FLUSH_CYCLES > 1) ? FLUSH : IDLE;

    fetch_redirect_state_t  state, state_nxt;
    logic [ADDR_W-1:0]      pend_addr, pend_addr_nxt;
    redirect_src_t          pend_src, pend_src_nxt;
    logic [FLUSH_CNT_W-1:0] flush_cnt, flush_cnt_nxt;

    redirect_src_t          win_src;
    logic [ADDR_W-1:0]      win_addr;
    logic [3:0]             win_grant;
    logic                   win_present;
    logic                   win_ge_pend;

    logic                   issue;
    logic [ADDR_W-1:0]      issue_addr;
    logic                   upc_c;
    logic [ADDR_W-1:0]      uaddr_c;
    logic                   flush_c;
    logic                   stall_c;
    logic [3:0]             grant_c;

    redirect_prio_sel #(.ADDR_W(ADDR_W)) u_prio (
        .trap_req  (trap_req),
        .trap_addr (trap_addr),
        .ret_req   (ret_req),
        .ret_addr  (ret_addr),
        .br_req    (br_req),
        .br_addr   (br_addr),
        .jmp_req   (jmp_req),
        .jmp_addr  (jmp_addr),
        .win_src   (win_src),
        .win_addr  (win_addr),
        .win_grant (win_grant)
    );

    assign win_present = (win_src != RS_NONE);
    // A held redirect yields only to an equal or higher-priority request.
    assign win_ge_pend = win_present && (win_src >= pend_src);

    always_comb begin
        state_nxt     = state;
        pend_addr_nxt = pend_addr;
        pend_src_nxt  = pend_src;
        flush_cnt_nxt = flush_cnt;
        issue         = 1'b0;
        issue_addr    = '0;
        upc_c         = 1'b0;
        uaddr_c       = '0;
        flush_c       = 1'b0;
        stall_c       = 1'b0;
        grant_c       = 4'b0000;

        case (state)
            PENDING: begin
                flush_c = 1'b1;
                if (win_ge_pend) grant_c = win_grant;
                if (fetch_busy) begin
                    stall_c = 1'b1;
                    if (win_ge_pend) begin
                        pend_addr_nxt = win_addr;
                        pend_src_nxt  = win_src;
                    end
                end else begin
                    issue      = 1'b1;
                    issue_addr = win_ge_pend ? win_addr : pend_addr;
                end
            end
            default: begin
                if (win_present) begin
                    grant_c = win_grant;
                    flush_c = 1'b1;
                    if (fetch_busy) begin
                        stall_c       = 1'b1;
                        pend_addr_nxt = win_addr;
                        pend_src_nxt  = win_src;
                        state_nxt     = PENDING;
                    end else begin
                        issue      = 1'b1;
                        issue_addr = win_addr;
                    end
                end else if (state == FLUSH) begin
                    flush_c = 1'b1;
                    if (flush_cnt <= 4'd1) begin
                        state_nxt     = IDLE;
                        flush_cnt_nxt = '0;
                    end else begin
                        flush_cnt_nxt = flush_cnt - 4'd1;
                    end
                end else begin
                    stall_c = hazard_stall;
                end
            end
        endcase

        // Issue is zero-latency and always overrides a hazard stall.
        if (issue) begin
            upc_c         = 1'b1;
            uaddr_c       = issue_addr;
            stall_c       = 1'b0;
            state_nxt     = ISSUE_NEXT;
            flush_cnt_nxt = FLUSH_RELOAD;
            pend_src_nxt  = RS_NONE;
        end

        if (RST) begin
            upc_c   = 1'b0;
            uaddr_c = '0;
            flush_c = 1'b0;
            stall_c = 1'b0;
            grant_c = 4'b0000;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            pend_addr <= '0;
            pend_src  <= RS_NONE;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            pend_addr <= pend_addr_nxt;
            pend_src  <= pend_src_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    assign fcif.update_pc   = upc_c;
    assign fcif.update_addr = uaddr_c;
    assign fcif.flush       = flush_c;
    assign fcif.stall       = stall_c;
    assign grant            = grant_c;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: two instances (FLUSH_CYCLES 1 and 3) on shared
// stimulus, directed scenarios plus randomized traffic against a reference model.
module tb_fetch_redirect_ctrl;

    localparam int FC0 = 1;
    localparam int FC1 = 3;

    logic        clk;
    logic        rst;
    logic        trap_req, ret_req, br_req, jmp_req;
    logic [31:0] trap_addr, ret_addr, br_addr, jmp_addr;
    logic        hazard_stall, fetch_busy;
    logic [3:0]  grant0, grant1;

    int n_tests;
    int n_fail;

    fetch_control_if #(.ADDR_W(32)) if0 ();
    fetch_control_if #(.ADDR_W(32)) if1 ();

    fetch_redirect_ctrl #(.FLUSH_CYCLES(FC0), .ADDR_W(32)) dut0 (
        .CLK(clk), .RST(rst), .fcif(if0.control),
        .trap_req(trap_req), .trap_addr(trap_addr),
        .ret_req(ret_req), .ret_addr(ret_addr),
        .br_req(br_req), .br_addr(br_addr),
        .jmp_req(jmp_req), .jmp_addr(jmp_addr),
        .hazard_stall(hazard_stall), .fetch_busy(fetch_busy),
        .grant(grant0)
    );

    fetch_redirect_ctrl #(.FLUSH_CYCLES(FC1), .ADDR_W(32)) dut1 (
        .CLK(clk), .RST(rst), .fcif(if1.control),
        .trap_req(trap_req), .trap_addr(trap_addr),
        .ret_req(ret_req), .ret_addr(ret_addr),
        .br_req(br_req), .br_addr(br_addr),
        .jmp_req(jmp_req), .jmp_addr(jmp_addr),
        .hazard_stall(hazard_stall), .fetch_busy(fetch_busy),
        .grant(grant1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed as {update_pc, update_addr, flush, stall, grant}.
    function automatic logic [38:0] obs(input int k);
        if (k == 0) return {if0.update_pc, if0.update_addr, if0.flush, if0.stall, grant0};
        return {if1.update_pc, if1.update_addr, if1.flush, if1.stall, grant1};
    endfunction

    // Reference model: a held redirect (valid/priority/target) plus a count of
    // flush cycles still owed after the current one.
    bit          m_pend [2];
    int          m_pp   [2];
    logic [31:0] m_pa   [2];
    int          m_fl   [2];
    bit          n_pend [2];
    int          n_pp   [2];
    logic [31:0] n_pa   [2];
    int          n_fl   [2];
    logic [38:0] m_exp  [2];

    task automatic model_eval(input int k);
        int          w, fc;
        logic [31:0] wa, ia, ua;
        logic [3:0]  wg, g;
        bit          upc, fl, st, iss;
        fc = (k == 0) ? FC0 : FC1;
        w = 0; wa = 0; wg = 0;
        if (jmp_req)  begin w = 1; wa = jmp_addr;  wg = 4'b0001; end
        if (br_req)   begin w = 2; wa = br_addr;   wg = 4'b0010; end
        if (ret_req)  begin w = 3; wa = ret_addr;  wg = 4'b0100; end
        if (trap_req) begin w = 4; wa = trap_addr; wg = 4'b1000; end
        upc = 0; ua = 0; fl = 0; st = 0; g = 0; iss = 0; ia = 0;
        n_pend[k] = m_pend[k]; n_pp[k] = m_pp[k]; n_pa[k] = m_pa[k]; n_fl[k] = m_fl[k];
        if (m_pend[k]) begin
            fl = 1;
            if (fetch_busy) st = 1;
            if (w > 0 && w >= m_pp[k]) begin
                g = wg;
                if (fetch_busy) begin n_pa[k] = wa; n_pp[k] = w; end
                else begin iss = 1; ia = wa; end
            end else if (!fetch_busy) begin
                iss = 1; ia = m_pa[k];
            end
        end else if (w > 0) begin
            g = wg; fl = 1;
            if (fetch_busy) begin
                st = 1; n_pend[k] = 1; n_pp[k] = w; n_pa[k] = wa; n_fl[k] = 0;
            end else begin
                iss = 1; ia = wa;
            end
        end else if (m_fl[k] > 0) begin
            fl = 1; n_fl[k] = m_fl[k] - 1;
        end else begin
            st = hazard_stall;
        end
        if (iss) begin
            upc = 1; ua = ia; n_pend[k] = 0; n_fl[k] = fc - 1;
        end
        m_exp[k] = rst ? 39'd0 : {upc, ua, fl, st, g};
    endtask

    task automatic model_commit(input int k);
        if (rst) begin
            m_pend[k] = 0; m_pp[k] = 0; m_pa[k] = 0; m_fl[k] = 0;
        end else begin
            m_pend[k] = n_pend[k]; m_pp[k] = n_pp[k]; m_pa[k] = n_pa[k]; m_fl[k] = n_fl[k];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_eval(0); model_eval(1);
        model_commit(0); model_commit(1);
        #1;
    endtask

    task automatic clear_in();
        trap_req = 0; ret_req = 0; br_req = 0; jmp_req = 0;
        trap_addr = 0; ret_addr = 0; br_addr = 0; jmp_addr = 0;
        hazard_stall = 0; fetch_busy = 0;
    endtask

    task automatic idle(input int n);
        clear_in();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        logic [38:0] o;
        rst = 1; clear_in();
        tick(); tick();
        rst = 0;
        ret_req = 1; ret_addr = 32'h0000_2000;
        tick();
        clear_in();
        rst = 1;
        trap_req = 1; ret_req = 1; br_req = 1; jmp_req = 1; hazard_stall = 1;
        trap_addr = 32'h100; ret_addr = 32'h200; br_addr = 32'h800; jmp_addr = 32'h400;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            o = obs(k);
            n_tests++;
            if (o !== 39'd0) begin
                n_fail++;
                $display("FAIL reset_outputs dut%0d got %h expected 0", k, o);
            end
        end
        tick();
        rst = 0; clear_in();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            o = obs(k);
            n_tests++;
            if (o !== 39'd0) begin
                n_fail++;
                $display("FAIL after_reset_idle dut%0d got %h expected 0", k, o);
            end
        end
        tick();
    endtask

    task automatic test_single_jump();
        logic [38:0] o, e;
        idle(4);
        jmp_req = 1; jmp_addr = 32'h0000_0400;
        @(negedge clk);
        o = obs(0); e = {1'b1, 32'h400, 1'b1, 1'b0, 4'b0001};
        n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL jump_issue got %h expected %h", o, e); end
        tick();
        clear_in();
        @(negedge clk);
        o = obs(0); e = 39'd0;
        n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL jump_after got %h expected %h", o, e); end
        tick();
    endtask

    task automatic test_priority();
        logic [38:0] o, e;
        idle(4);
        trap_req = 1; trap_addr = 32'h0000_0100;
        br_req = 1;   br_addr = 32'h0000_0800;
        @(negedge clk);
        e = {1'b1, 32'h100, 1'b1, 1'b0, 4'b1000};
        for (int k = 0; k < 2; k++) begin
            o = obs(k);
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL trap_over_br dut%0d got %h expected %h", k, o, e); end
        end
        tick();
    endtask

    task automatic test_busy_pending();
        logic [38:0] o;
        logic [38:0] e [4];
        e[0] = {1'b0, 32'h0,   1'b1, 1'b1, 4'b0010};
        e[1] = {1'b0, 32'h0,   1'b1, 1'b1, 4'b1000};
        e[2] = {1'b0, 32'h0,   1'b1, 1'b1, 4'b0000};
        e[3] = {1'b1, 32'h100, 1'b1, 1'b0, 4'b0000};
        idle(4);
        for (int c = 0; c < 4; c++) begin
            clear_in();
            fetch_busy = (c < 3);
            if (c == 0) begin br_req = 1;   br_addr = 32'h800;   end
            if (c == 1) begin trap_req = 1; trap_addr = 32'h100; end
            if (c == 2) begin jmp_req = 1;  jmp_addr = 32'h400;  end
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                o = obs(k);
                n_tests++;
                if (o !== e[c]) begin
                    n_fail++;
                    $display("FAIL busy_pending c%0d dut%0d got %h expected %h", c, k, o, e[c]);
                end
            end
            tick();
        end
        clear_in();
    endtask

    task automatic test_flush3();
        idle(4);
        for (int c = 0; c < 5; c++) begin
            clear_in();
            if (c == 0) begin ret_req = 1; ret_addr = 32'h0000_2000; end
            @(negedge clk);
            n_tests++;
            if (if1.flush !== (c < 3) || if1.update_pc !== (c == 0)) begin
                n_fail++;
                $display("FAIL flush3 c%0d got flush=%b upc=%b expected flush=%b upc=%b",
                         c, if1.flush, if1.update_pc, (c < 3), (c == 0));
            end
            tick();
        end
        clear_in();
    endtask

    task automatic test_hazard();
        logic [38:0] o, e;
        idle(4);
        hazard_stall = 1;
        @(negedge clk);
        o = obs(0); e = {1'b0, 32'h0, 1'b0, 1'b1, 4'b0000};
        n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL hazard_only got %h expected %h", o, e); end
        jmp_req = 1; jmp_addr = 32'h0000_0040;
        #1;
        o = obs(0); e = {1'b1, 32'h40, 1'b1, 1'b0, 4'b0001};
        n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL hazard_with_jump got %h expected %h", o, e); end
        tick();
        clear_in();
    endtask

    task automatic test_random();
        logic [38:0] o;
        for (int c = 0; c < 600; c++) begin
            rst          = ($urandom_range(99) == 0);
            trap_req     = ($urandom_range(7) == 0);
            ret_req      = ($urandom_range(5) == 0);
            br_req       = ($urandom_range(3) == 0);
            jmp_req      = ($urandom_range(3) == 0);
            trap_addr    = $urandom;
            ret_addr     = $urandom;
            br_addr      = $urandom;
            jmp_addr     = $urandom;
            hazard_stall = ($urandom_range(3) == 0);
            fetch_busy   = ($urandom_range(2) == 0);
            @(negedge clk);
            model_eval(0); model_eval(1);
            for (int k = 0; k < 2; k++) begin
                o = obs(k);
                n_tests++;
                if (o !== m_exp[k]) begin
                    n_fail++;
                    $display("FAIL random c%0d dut%0d got %h expected %h", c, k, o, m_exp[k]);
                end
            end
            tick();
        end
        rst = 0;
        clear_in();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = 0; m_pp[k] = 0; m_pa[k] = 0; m_fl[k] = 0;
        end
        rst = 1;
        clear_in();
        #1;
        test_reset();
        test_single_jump();
        test_priority();
        test_busy_pending();
        test_flush3();
        test_hazard();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
